// File: rtl/alarm_controller_if.sv
// Sensor/enable inputs and siren/indicator outputs of the alarm controller.
// master = sensor conditioning / driver side, slave = the controller itself.
interface alarm_controller_if #(
  parameter int N_SENSORS = 4
);
  logic [N_SENSORS-1:0] i_sensor;
  logic                 i_enable;
  logic                 o_alarm_state;
  logic                 o_armed;
  logic                 o_arming;
  logic                 o_pending;
  logic [N_SENSORS-1:0] o_zone_latch;

  modport master (
    output i_sensor, i_enable,
    input  o_alarm_state, o_armed, o_arming, o_pending, o_zone_latch
  );

  modport slave (
    input  i_sensor, i_enable,
    output o_alarm_state, o_armed, o_arming, o_pending, o_zone_latch
  );
endinterface

// File: rtl/alarm_controller.sv
// Arm/disarm alarm FSM with exit delay, entry delay, instant zones, timed siren
// and a sticky record of tripped zones. All outputs are registered.
module alarm_controller #(
  parameter int                   N_SENSORS    = 4,
  parameter int                   EXIT_DELAY   = 8,
  parameter int                   ENTRY_DELAY  = 8,
  parameter int                   SIREN_TIME   = 16,
  parameter logic [N_SENSORS-1:0] INSTANT_MASK = '0
) (
  input logic               i_clk,
  input logic               i_rst,
  alarm_controller_if.slave bus
);

  localparam int MAX_A   = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
  localparam int MAX_DLY = (MAX_A > SIREN_TIME) ? MAX_A : SIREN_TIME;
  localparam int CW      = $clog2(MAX_DLY) + 1;

  typedef enum logic [2:0] {
    S_DISARMED,
    S_EXIT,
    S_ARMED,
    S_ENTRY,
    S_SIREN
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [N_SENSORS-1:0] r_zone;
  logic [N_SENSORS-1:0] w_zone_nxt;
  logic                 r_alarm;
  logic                 r_armed;
  logic                 r_arming;
  logic                 r_pending;
  logic                 w_trip;
  logic                 w_instant;
  logic                 w_cnt_zero;

  assign w_trip     = |bus.i_sensor;
  assign w_instant  = |(bus.i_sensor & INSTANT_MASK);
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_zone_nxt  = r_zone;

    // Zones accumulate in every armed state, including the cycle Enable drops.
    if (r_state == S_ARMED || r_state == S_ENTRY || r_state == S_SIREN)
      w_zone_nxt = r_zone | bus.i_sensor;

    if (!bus.i_enable) begin
      w_state_nxt = S_DISARMED;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_DISARMED: begin
          w_state_nxt = S_EXIT;
          w_cnt_nxt   = CW'(EXIT_DELAY - 1);
          w_zone_nxt  = '0;
        end
        S_EXIT: begin
          if (w_cnt_zero) w_state_nxt = S_ARMED;
          else            w_cnt_nxt   = r_cnt - CW'(1);
        end
        S_ARMED: begin
          if (w_instant) begin
            w_state_nxt = S_SIREN;
            w_cnt_nxt   = CW'(SIREN_TIME - 1);
          end else if (w_trip) begin
            w_state_nxt = S_ENTRY;
            w_cnt_nxt   = CW'(ENTRY_DELAY - 1);
          end
        end
        S_ENTRY: begin
          if (w_instant || w_cnt_zero) begin
            w_state_nxt = S_SIREN;
            w_cnt_nxt   = CW'(SIREN_TIME - 1);
          end else begin
            w_cnt_nxt   = r_cnt - CW'(1);
          end
        end
        S_SIREN: begin
          if (w_cnt_zero) w_state_nxt = S_ARMED;
          else            w_cnt_nxt   = r_cnt - CW'(1);
        end
        default: begin
          w_state_nxt = S_DISARMED;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_DISARMED;
      r_cnt     <= '0;
      r_zone    <= '0;
      r_alarm   <= 1'b0;
      r_armed   <= 1'b0;
      r_arming  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_zone    <= w_zone_nxt;
      r_alarm   <= (w_state_nxt == S_SIREN);
      r_armed   <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_ENTRY) ||
                   (w_state_nxt == S_SIREN);
      r_arming  <= (w_state_nxt == S_EXIT);
      r_pending <= (w_state_nxt == S_ENTRY);
    end
  end

  assign bus.o_alarm_state = r_alarm;
  assign bus.o_armed       = r_armed;
  assign bus.o_arming      = r_arming;
  assign bus.o_pending     = r_pending;
  assign bus.o_zone_latch  = r_zone;

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Parametrised, clocked successor to the combinational alarm block. It monitors N entry sensors and runs an arm/disarm state machine with an exit delay, an entry delay, instant-trip zones and a timed siren. It also latches which zones tripped. It sits between the sensor input conditioning and the siren/indicator drivers.

## Interface
- N_SENSORS, 4, number of sensor inputs (≥1)
- EXIT_DELAY, 8, cycles spent in EXIT before the system is armed (≥1)
- ENTRY_DELAY, 8, cycles of grace in ENTRY before the siren sounds (≥1)
- SIREN_TIME, 16, cycles the siren stays on before auto re-arm (≥1)
- INSTANT_MASK, {N_SENSORS{1'b0}}, per-sensor bit; 1 = zone bypasses entry delay

Ports:
- Clock  in  1  system clock; all state changes on its rising edge
- Reset  in  1  synchronous, active-high reset
- Sensor  in  N_SENSORS  HIGH if the entry is open
- Enable  in  1  level arm request; HIGH = armed, LOW = disarm
- Alarm_State  out  1  HIGH while the siren sounds
- Armed  out  1  HIGH in ARMED, ENTRY or SIREN
- Arming  out  1  HIGH in EXIT
- Pending  out  1  HIGH in ENTRY
- Zone_Latch  out  N_SENSORS  sticky record of zones that tripped while armed

## Operation
- FSM states are DISARMED, EXIT, ARMED, ENTRY and SIREN.
- All outputs are registered Moore outputs decoded from the state, plus the Zone_Latch register.
- A single down-counter (`cnt`) serves all timed states. Its width is `$clog2` of the largest of EXIT_DELAY, ENTRY_DELAY and SIREN_TIME, plus 1.
- Reset:
  - state = DISARMED, `cnt` = 0, Zone_Latch = 0.
  - All outputs are 0.
  - Reset overrides every other input in the same cycle.
- Enable LOW overrides everything except Reset: from any state, the next state is DISARMED and `cnt` is cleared.
- Zone_Latch holds its value in DISARMED.
- DISARMED → EXIT when Enable = 1:
  - load `cnt` = EXIT_DELAY-1;
  - clear Zone_Latch.
- EXIT:
  - Sensors are ignored.
  - If `cnt` = 0, go to ARMED; otherwise decrement `cnt`.
- ARMED, with `trip` = |Sensor:
  - If (Sensor & INSTANT_MASK) ≠ 0, go to SIREN and load `cnt` = SIREN_TIME-1.
  - Else if `trip`, go to ENTRY and load `cnt` = ENTRY_DELAY-1.
- ENTRY:
  - An instant-zone sensor active goes to SIREN immediately and loads `cnt` = SIREN_TIME-1.
  - Else, if `cnt` = 0, go to SIREN and load `cnt` = SIREN_TIME-1.
  - Else decrement `cnt`.
  - Sensors closing during ENTRY do not cancel it; only Enable LOW does.
- SIREN:
  - If `cnt` = 0, go to ARMED; otherwise decrement `cnt`.
  - Further trips do not extend the siren.
- Auto re-arm after SIREN: a sensor still open in ARMED re-triggers on the next cycle. This is intended.
- Zone_Latch:
  - In ARMED, ENTRY and SIREN, `Zone_Latch <= Zone_Latch | Sensor` every cycle.
  - Zone_Latch is never cleared except by Reset or by the DISARMED→EXIT transition.

## Timing
- Edge numbering: the edge that samples an input is edge k, and the new state/outputs are visible after edge k. Input-to-output latency is therefore 1 cycle.
- Arming: Enable rises and is sampled at edge 0.
  - Arming = 1 after edges 0 through EXIT_DELAY-1.
  - Armed = 1 after edge EXIT_DELAY.
- Entry: a non-instant trip is sampled at edge t.
  - Pending = 1 for ENTRY_DELAY cycles.
  - Alarm_State = 1 after edge t+ENTRY_DELAY.
- Instant trip sampled at edge t: Alarm_State = 1 after edge t.
- Siren: Alarm_State stays HIGH for exactly SIREN_TIME cycles, then ARMED resumes (Alarm_State = 0, Armed = 1).
- Disarm: Enable = 0 sampled at edge d gives all of Arming, Armed, Pending and Alarm_State = 0 after edge d. This holds in every state.
- Simultaneous events:
  - Reset beats Enable.
  - Enable LOW beats sensor trips and counter expiry.
  - An instant trip beats entry-delay expiry; the result is the same state either way.
- Reset mid-operation (e.g. during SIREN): everything is 0 after the reset edge, including Zone_Latch.

## Test plan
Defaults unless stated otherwise, with INSTANT_MASK = 4'b1000.

1. **Reset**: Reset = 1 for 2 cycles with Sensor = 4'hF and Enable = 1 → all outputs 0 and Zone_Latch = 0. On release, Arming = 1 after the next edge.
2. **Exit delay, then entry timeout**:
   - Enable = 1 at edge 0 → Armed = 1 after edge 8.
   - Sensor = 4'b0001 pulsed for 1 cycle at edge 10 → Pending = 1 after edges 10–17, Alarm_State = 1 after edges 18–33, Armed re-asserts after edge 34.
   - Zone_Latch = 4'b0001 throughout.
3. **Disarm during entry**: as scenario 2, but Enable = 0 at edge 14 → all outputs 0 after edge 14, no siren, and Zone_Latch = 4'b0001 retained.
4. **Instant zone**: armed, Sensor = 4'b1000 at edge t → Alarm_State = 1 after edge t, Pending never set.
5. **Instant trip during entry**: Sensor = 4'b0010 at edge t, then 4'b1010 at edge t+3 → Alarm_State = 1 after edge t+3, Zone_Latch = 4'b1010.
6. **Exit ignores sensors**: Sensor = 4'hF held during EXIT, dropped to 0 at the edge before arming completes → no trip and Zone_Latch = 0. A second run with Sensor held through arming → Pending = 1 one cycle after Armed asserts.
